commit_arbiter: RTL
===================

# commit_arbiter

Per-issue-slot commit arbiter that sits directly downstream of the gather stage's per-slot commit outputs. It merges the commit streams of `NUM_REQS` execute units into one writeback stream. Arbitration is round-robin with packet locking on `sop`/`eop`, so multi-beat results are never interleaved. It also keeps committed-instruction and committed-thread counters for the performance monitor.

## Interface
Parameters:
- `NUM_REQS`, 4, number of execute-unit commit streams arbitrated (≥1).
- `CTR_W`, 44, width of the performance counters.

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  `NUM_REQS`  per-requester beat valid.
- `in_data`  in  `NUM_REQS` × `commit_data_t`  per-requester beat (uuid, wid, tmask, PC, wb, rd, data, pid, sop, eop, rrs_id).
- `in_ready`  out  `NUM_REQS`  per-requester accept.
- `out_valid`  out  1  registered output beat valid.
- `out_data`  out  `commit_data_t`  registered output beat.
- `out_ready`  in  1  writeback accept.
- `out_grant`  out  `LOG2UP(NUM_REQS)`  index of the requester that produced `out_data`.
- `instr_count`  out  `CTR_W`  committed instructions.
- `thread_count`  out  `CTR_W`  committed active threads.

## Operation
- Input accept: `in_fire[i] = in_valid[i] & in_ready[i]`. At most one `in_ready` is high per cycle.
- `in_ready[g] = grant_valid & (g == grant) & (~out_valid | out_ready)`.
- State machine:
  - IDLE: `grant` is the first valid requester searching from `rr_ptr` upward, wrapping modulo `NUM_REQS`.
  - LOCKED(`lock_idx`): `grant = lock_idx`. Granted only when `in_valid[lock_idx]`; all other `in_ready` are 0.
- Transitions:
  - IDLE → LOCKED(g) on `in_fire[g]` with `eop == 0`.
  - LOCKED → IDLE on `in_fire[lock_idx]` with `eop == 1`.
  - A single-beat packet (`sop = eop = 1`) stays in IDLE.
- `rr_ptr` ← `(g + 1) mod NUM_REQS` on every accepted `eop` beat; unchanged on other beats. For `NUM_REQS == 1`, `rr_ptr` is a constant 0.
- `sop` is not checked. A beat with `sop = 1` arriving while LOCKED is forwarded as is; upstream framing is the producer's responsibility.
- Output register, loaded on any `in_fire`:
  - `out_valid` ← 1, `out_data` ← `in_data[grant]`, `out_grant` ← `grant`.
  - Else if `out_ready`: `out_valid` ← 0.
- Counters update on `out_fire = out_valid & out_ready`:
  - `thread_count` += popcount(`out_data.tmask`) for every beat.
  - `instr_count` += 1 when `out_data.eop`.
  - Both wrap modulo 2^`CTR_W` silently.

## Timing
- Latency: 1 cycle from `in_fire` to `out_valid`. Full throughput of 1 beat/cycle while `out_ready` stays high.
- Backpressure: while `out_valid & ~out_ready`, all `in_ready` are 0 and `out_data` holds stable.
- `out_data` and `out_grant` change only on `in_fire`.
- Same-cycle `out_fire` and `in_fire`: the register reloads and `out_valid` stays 1. Counters use the departing beat.
- Reset (asynchronous, `reset == 0`):
  - `out_valid = 0`, `out_data = '0`, `out_grant = 0`.
  - `state = IDLE`, `rr_ptr = 0`, `instr_count = 0`, `thread_count = 0`.
  - `in_ready` = 0 while reset is asserted.
- Reset mid-packet discards the lock; the remaining beats are treated as fresh arbitration. Upstream is reset by the same signal.
- Release: state is effective from the first rising edge after `reset` deasserts.

## Structure
- Shared package (`VX_gpu_pkg`):
  - `commit_data_t`, the packed struct shared with gather/writeback.
  - Field widths `RRS_WIS_W` and `PID_WIDTH`.
- Arbiter constants stay local.
- Sub-module: `rr_lock_arbiter`. It is generic round-robin with hold/unlock inputs and has no knowledge of `commit_data_t`.
- The output register, popcount and counters live in the top level.

## Test plan
- Single beat: `in_valid = 4'b0100`, `eop = sop = 1`, `tmask = 4'b1011`, `out_ready = 1` → `out_valid` next cycle with `out_grant = 2`. One cycle later `instr_count = 1`, `thread_count = 3`.
- Fairness: all four inputs continuously valid with single-beat packets → grants 0,1,2,3,0,… in order, one per cycle. No requester is starved over 100 cycles.
- Locking:
  - Stimulus: requester 1 sends 3 beats (`sop` on beat 0, `eop` on beat 2) with gaps; requester 0 is valid throughout.
  - Required: requester 0 gets no `in_ready` until beat 2 is accepted.
  - After the lock releases, the next grant goes to requester 2 if it is valid, otherwise to requester 0.
- Backpressure: `out_ready = 0` for 5 cycles with inputs valid → `out_data` stable, all `in_ready = 0`, counters frozen. When `out_ready` returns to 1, the next beat follows on the following cycle.
- Wrap: `CTR_W = 4` with `instr_count` preloaded to 15 via a 15-packet run → the 16th `eop` beat makes it 0.
- Reset mid-packet:
  - Stimulus: assert `reset = 0` asynchronously during LOCKED.
  - Required: `out_valid` drops immediately and the counters clear.
  - After release, requester 3 single-beat is granted even though the lock had been on requester 1.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// VX_gpu_pkg: commit beat format shared by gather, commit arbitration and writeback,
// plus the thread-mask popcount used by the performance counters.
package VX_gpu_pkg;

    localparam int NUM_THREADS = 4;
    localparam int NUM_WARPS   = 4;
    localparam int XLEN        = 32;
    localparam int NR_BITS     = 5;
    localparam int UUID_WIDTH  = 44;
    localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int PID_WIDTH   = 1;
    localparam int RRS_WIS_W   = 2;
    localparam int TCNT_W      = $clog2(NUM_THREADS + 1);

    typedef struct packed {
        logic [UUID_WIDTH-1:0]       uuid;
        logic [NW_WIDTH-1:0]         wid;
        logic [NUM_THREADS-1:0]      tmask;
        logic [XLEN-1:0]             pc;
        logic                        wb;
        logic [NR_BITS-1:0]          rd;
        logic [NUM_THREADS*XLEN-1:0] data;
        logic [PID_WIDTH-1:0]        pid;
        logic                        sop;
        logic                        eop;
        logic [RRS_WIS_W-1:0]        rrs_id;
    } commit_data_t;

    function automatic logic [TCNT_W-1:0] tmask_popcount(input logic [NUM_THREADS-1:0] m);
        logic [TCNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_THREADS; i++) c = c + TCNT_W'(m[i]);
        return c;
    endfunction

endpackage

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin arbiter that holds its grant for the whole of a multi-beat packet.
// Payload-agnostic: the caller reports each accepted beat and whether it closed the packet.
module rr_lock_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             accept,
    input  logic             last,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] cand;

    // Scan downward so the candidate closest to rr_ptr is the one left standing.
    always_comb begin
        grant_valid = 1'b0;
        grant       = rr_ptr_q;
        cand        = '0;
        if (state_q == LOCKED) begin
            grant       = lock_idx_q;
            grant_valid = req[lock_idx_q];
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                cand = IDX_W'((int'(rr_ptr_q) + k) % N);
                if (req[cand]) begin
                    grant_valid = 1'b1;
                    grant       = cand;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (accept) begin
            state_d    = last ? IDLE : LOCKED;
            lock_idx_d = grant;
            rr_ptr_d   = last ? IDX_W'((int'(grant) + 1) % N) : rr_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/commit_arbiter.sv
// commit_arbiter: merges per-unit commit streams into one registered writeback stream,
// never interleaving packets, and counts committed instructions and active threads.
module commit_arbiter
    import VX_gpu_pkg::*;
#(
    parameter  int NUM_REQS = 4,
    parameter  int CTR_W    = 44,
    localparam int GRANT_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQS-1:0] in_valid,
    input  commit_data_t       in_data [NUM_REQS],
    output logic [NUM_REQS-1:0] in_ready,
    output logic               out_valid,
    output commit_data_t       out_data,
    input  logic               out_ready,
    output logic [GRANT_W-1:0] out_grant,
    output logic [CTR_W-1:0]   instr_count,
    output logic [CTR_W-1:0]   thread_count
);

    logic               grant_valid, can_load, in_fire, out_fire;
    logic [GRANT_W-1:0] grant;
    logic               out_valid_q, out_valid_d;
    commit_data_t       out_data_q, out_data_d;
    logic [GRANT_W-1:0] out_grant_q, out_grant_d;
    logic [CTR_W-1:0]   instr_count_q, instr_count_d;
    logic [CTR_W-1:0]   thread_count_q, thread_count_d;

    rr_lock_arbiter #(
        .N     (NUM_REQS),
        .IDX_W (GRANT_W)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (in_valid),
        .accept      (in_fire),
        .last        (in_data[grant].eop),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Gating with reset keeps every in_ready low while reset is held.
    always_comb begin
        can_load = reset & (~out_valid_q | out_ready);
        in_fire  = grant_valid & can_load;
        out_fire = out_valid_q & out_ready;
        in_ready = '0;
        for (int g = 0; g < NUM_REQS; g++) in_ready[g] = in_fire & (grant == GRANT_W'(g));
        out_valid_d    = in_fire | (out_valid_q & ~out_ready);
        out_data_d     = in_fire ? in_data[grant] : out_data_q;
        out_grant_d    = in_fire ? grant : out_grant_q;
        instr_count_d  = instr_count_q + CTR_W'(out_fire & out_data_q.eop);
        thread_count_d = thread_count_q + (out_fire ? CTR_W'(tmask_popcount(out_data_q.tmask)) : '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_grant_q    <= '0;
            instr_count_q  <= '0;
            thread_count_q <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_grant_q    <= out_grant_d;
            instr_count_q  <= instr_count_d;
            thread_count_q <= thread_count_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_grant    = out_grant_q;
    assign instr_count  = instr_count_q;
    assign thread_count = thread_count_q;

endmodule
